// File: rtl/ysyx_220066_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: MemOp encodings, FSM states and owners.
package ysyx_220066_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } arbState_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_220066_mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshakes around the arbiter.
// slave = arbiter view, master = environment (CPU + memory model) view.
interface ysyx_220066_mem_arbiter_if #(
  parameter int AW = 64
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_rsp_valid;
  logic [31:0]   if_rsp_data;

  logic          ls_req_valid;
  logic          ls_req_ready;
  logic [AW-1:0] ls_addr;
  logic          ls_wen;
  logic [2:0]    ls_memop;
  logic [63:0]   ls_wdata;
  logic          ls_rsp_valid;
  logic [63:0]   ls_rsp_data;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [7:0]    mem_wmask;
  logic [63:0]   mem_wdata;
  logic          mem_rsp_valid;
  logic [63:0]   mem_rsp_data;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_addr, ls_wen, ls_memop, ls_wdata,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_addr, ls_wen, ls_memop, ls_wdata,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/ysyx_220066_mem_arbiter_lsu_align.sv
// Combinational byte-lane logic: store mask/data replication and load extract/extend.
module ysyx_220066_lsu_align
  import ysyx_220066_mem_pkg::*;
(
  input  logic [2:0]  addr_i,
  input  logic [2:0]  memop_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  wmask_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] wordVal;

  always_comb begin
    wmask_o = 8'hFF;
    wdata_o = wdata_i;
    case (memop_i[1:0])
      2'b00: begin
        wmask_o = 8'b1 << addr_i;
        wdata_o = {8{wdata_i[7:0]}};
      end
      2'b01: begin
        wmask_o = 8'b11 << {addr_i[2:1], 1'b0};
        wdata_o = {4{wdata_i[15:0]}};
      end
      2'b10: begin
        wmask_o = addr_i[2] ? 8'hF0 : 8'h0F;
        wdata_o = {2{wdata_i[31:0]}};
      end
      default: begin
        wmask_o = 8'hFF;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Address bits below the access size are dropped, so misaligned loads wrap inside the lane.
  always_comb begin
    byteVal = rdata_i[{addr_i, 3'b000} +: 8];
    halfVal = rdata_i[{addr_i[2:1], 4'b0000} +: 16];
    wordVal = rdata_i[{addr_i[2], 5'b00000} +: 32];
    rdata_o = rdata_i;
    case (memop_i[1:0])
      2'b00:   rdata_o = memop_i[2] ? {56'b0, byteVal} : {{56{byteVal[7]}}, byteVal};
      2'b01:   rdata_o = memop_i[2] ? {48'b0, halfVal} : {{48{halfVal[15]}}, halfVal};
      2'b10:   rdata_o = memop_i[2] ? {32'b0, wordVal} : {{32{wordVal[31]}}, wordVal};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_mem_arbiter.sv
// Two-requester arbiter (IFU read-only, LSU read/write) in front of one 64-bit memory port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the LSU has fixed priority.
module ysyx_220066_mem_arbiter
  import ysyx_220066_mem_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_220066_mem_arbiter_if.slave  bus,
  output logic                      busy
);

  arbState_e     state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [2:0]    memop_q, memop_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          preferIf;
  logic          grantIf;
  logic          grantLs;

  logic [7:0]    alignMask;
  logic [63:0]   alignWdata;
  logic [63:0]   alignRdata;

`ifdef MEM_ARB_RR_EN
  owner_e lastGrant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= OWN_LS;
    end else if (state_q == IDLE && (grantIf || grantLs)) begin
      lastGrant_q <= grantLs ? OWN_LS : OWN_IF;
    end
  end

  assign preferIf = (lastGrant_q == OWN_LS);
`else
  assign preferIf = 1'b0;
`endif

  // The IFU only wins a tie when the round-robin pointer says so.
  assign grantIf = bus.if_req_valid && (!bus.ls_req_valid || preferIf);
  assign grantLs = bus.ls_req_valid && !grantIf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LS;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      memop_q <= LD;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      memop_q <= memop_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    memop_d          = memop_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    bus.if_req_ready = 1'b0;
    bus.ls_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.if_req_ready = grantIf;
        bus.ls_req_ready = grantLs;
        if (grantLs) begin
          owner_d = OWN_LS;
          addr_d  = bus.ls_addr;
          wen_d   = bus.ls_wen;
          memop_d = bus.ls_memop;
          wdata_d = bus.ls_wdata;
          state_d = REQ;
        end else if (grantIf) begin
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          wen_d   = 1'b0;
          memop_d = LWU;
          wdata_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          rdata_d = bus.mem_rsp_data;
          state_d = RSP;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  ysyx_220066_lsu_align u_align (
    .addr_i  (addr_q[2:0]),
    .memop_i (memop_q),
    .wdata_i (wdata_q),
    .rdata_i (rdata_q),
    .wmask_o (alignMask),
    .wdata_o (alignWdata),
    .rdata_o (alignRdata)
  );

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = {addr_q[AW-1:3], 3'b000};
  assign bus.mem_wen       = (state_q == REQ) && wen_q;
  assign bus.mem_wmask     = bus.mem_wen ? alignMask : 8'h00;
  assign bus.mem_wdata     = alignWdata;

  // Response data is held in registers, so it stays stable after the one-cycle valid pulse.
  assign bus.if_rsp_valid  = (state_q == RSP) && (owner_q == OWN_IF);
  assign bus.if_rsp_data   = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign bus.ls_rsp_valid  = (state_q == RSP) && (owner_q == OWN_LS);
  assign bus.ls_rsp_data   = (owner_q == OWN_LS && !wen_q) ? alignRdata : 64'h0;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
// Directed self-checking bench for ysyx_220066_mem_arbiter (default build or MEM_ARB_RR_EN).
module tb_ysyx_220066_mem_arbiter;
  import ysyx_220066_mem_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

`ifdef MEM_ARB_RR_EN
  localparam bit FIRST_LS = 1'b0;
`else
  localparam bit FIRST_LS = 1'b1;
`endif

  ysyx_220066_mem_arbiter_if #(.AW(64)) bus ();

  ysyx_220066_mem_arbiter #(.AW(64), .DW(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  logic [2:0]  refAddr;
  logic [2:0]  refMemop;
  logic [63:0] refWdata;
  logic [63:0] refRdata;
  logic [7:0]  refMask;
  logic [63:0] refWdataOut;
  logic [63:0] refRdataOut;

  ysyx_220066_lsu_align refAlign (
    .addr_i  (refAddr),
    .memop_i (refMemop),
    .wdata_i (refWdata),
    .rdata_i (refRdata),
    .wmask_o (refMask),
    .wdata_o (refWdataOut),
    .rdata_o (refRdataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic [2:0] memop, input logic [63:0] addr,
                               input logic [63:0] wdata);
    bus.ls_req_valid = 1'b1;
    bus.ls_wen       = wen;
    bus.ls_memop     = memop;
    bus.ls_addr      = addr;
    bus.ls_wdata     = wdata;
  endtask

  // Called in the REQ cycle; leaves the DUT in its RSP cycle.
  task automatic serveMem(input logic [63:0] rdata);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checkOutput("wait_req_low", bus.mem_req_valid, 64'd0);
    checkOutput("wait_no_rsp", bus.ls_rsp_valid | bus.if_rsp_valid, 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = rdata;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 64'h0;
  endtask

  task automatic lsAccess(input string tag, input logic wen, input logic [2:0] memop,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                          input logic [7:0] expMask, input logic [63:0] expWdata,
                          input logic [63:0] expRsp);
    applyStimulus(wen, memop, addr, wdata);
    #1;
    checkOutput({tag, "_ls_ready"}, bus.ls_req_ready, 64'd1);
    checkOutput({tag, "_if_ready"}, bus.if_req_ready, 64'd0);
    tick();
    bus.ls_req_valid = 1'b0;
    checkOutput({tag, "_req_valid"}, bus.mem_req_valid, 64'd1);
    checkOutput({tag, "_addr"}, bus.mem_addr, {addr[63:3], 3'b000});
    checkOutput({tag, "_wen"}, bus.mem_wen, {63'd0, wen});
    checkOutput({tag, "_wmask"}, bus.mem_wmask, {56'd0, expMask});
    checkOutput({tag, "_wdata"}, bus.mem_wdata, expWdata);
    serveMem(rdata);
    checkOutput({tag, "_rsp_valid"}, bus.ls_rsp_valid, 64'd1);
    checkOutput({tag, "_rsp_data"}, bus.ls_rsp_data, expRsp);
    checkOutput({tag, "_if_rsp_quiet"}, bus.if_rsp_valid, 64'd0);
    tick();
    checkOutput({tag, "_rsp_pulse_end"}, bus.ls_rsp_valid, 64'd0);
    checkOutput({tag, "_idle"}, busy, 64'd0);
  endtask

  task automatic ifFetch(input string tag, input logic [63:0] addr, input logic [63:0] rdata,
                         input logic [31:0] expInstr);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = addr;
    #1;
    checkOutput({tag, "_if_ready"}, bus.if_req_ready, 64'd1);
    checkOutput({tag, "_ls_ready"}, bus.ls_req_ready, 64'd0);
    tick();
    bus.if_req_valid = 1'b0;
    checkOutput({tag, "_req_valid"}, bus.mem_req_valid, 64'd1);
    checkOutput({tag, "_addr"}, bus.mem_addr, {addr[63:3], 3'b000});
    checkOutput({tag, "_wen"}, bus.mem_wen, 64'd0);
    checkOutput({tag, "_wmask"}, bus.mem_wmask, 64'd0);
    serveMem(rdata);
    checkOutput({tag, "_rsp_valid"}, bus.if_rsp_valid, 64'd1);
    checkOutput({tag, "_rsp_data"}, bus.if_rsp_data, {32'd0, expInstr});
    checkOutput({tag, "_ls_rsp_quiet"}, bus.ls_rsp_valid, 64'd0);
    tick();
    checkOutput({tag, "_rsp_pulse_end"}, bus.if_rsp_valid, 64'd0);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    bus.if_req_valid  = 1'b0;
    bus.if_addr       = 64'h0;
    bus.ls_req_valid  = 1'b0;
    bus.ls_addr       = 64'h0;
    bus.ls_wen        = 1'b0;
    bus.ls_memop      = LD;
    bus.ls_wdata      = 64'h0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 64'h0;
    refAddr           = 3'd3;
    refMemop          = LB;
    refWdata          = 64'h5A;
    refRdata          = 64'h0;

    #1;
    checkOutput("ref_sb_mask", {56'd0, refMask}, 64'h08);
    checkOutput("ref_sb_wdata", refWdataOut, 64'h5A5A5A5A5A5A5A5A);
    refAddr  = 3'd6;
    refMemop = LH;
    refRdata = 64'h8001_0000_0000_0000;
    #1;
    checkOutput("ref_lh_rdata", refRdataOut, 64'hFFFFFFFFFFFF8001);

    tick();
    tick();
    checkOutput("rst_busy", busy, 64'd0);
    checkOutput("rst_mem_req_valid", bus.mem_req_valid, 64'd0);
    checkOutput("rst_mem_wen", bus.mem_wen, 64'd0);
    checkOutput("rst_mem_wmask", bus.mem_wmask, 64'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 64'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 64'd0);
    checkOutput("rst_if_rsp_valid", bus.if_rsp_valid, 64'd0);
    checkOutput("rst_ls_rsp_valid", bus.ls_rsp_valid, 64'd0);
    checkOutput("rst_if_rsp_data", bus.if_rsp_data, 64'd0);
    checkOutput("rst_ls_rsp_data", bus.ls_rsp_data, 64'd0);
    rst = 1'b0;

    // Tie straight after reset: fixed priority picks LSU, round-robin (last = LSU) picks IFU.
    applyStimulus(1'b0, LD, 64'h2008, 64'h0);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h8000_0000;
    #1;
    checkOutput("tie_ls_ready", bus.ls_req_ready, {63'd0, FIRST_LS});
    checkOutput("tie_if_ready", bus.if_req_ready, {63'd0, !FIRST_LS});
    tick();
    if (FIRST_LS) bus.ls_req_valid = 1'b0;
    else          bus.if_req_valid = 1'b0;
    checkOutput("tie_first_addr", bus.mem_addr, FIRST_LS ? 64'h2008 : 64'h8000_0000);
    checkOutput("tie_loser_blocked", bus.if_req_ready | bus.ls_req_ready, 64'd0);
    serveMem(FIRST_LS ? 64'h0123456789ABCDEF : 64'hCAFEBABE_DEADBEEF);
    checkOutput("tie_first_rsp", FIRST_LS ? bus.ls_rsp_valid : bus.if_rsp_valid, 64'd1);
    checkOutput("tie_first_other_quiet", FIRST_LS ? bus.if_rsp_valid : bus.ls_rsp_valid, 64'd0);
    checkOutput("tie_first_data", FIRST_LS ? bus.ls_rsp_data : {32'd0, bus.if_rsp_data},
                FIRST_LS ? 64'h0123456789ABCDEF : 64'hDEADBEEF);
    tick();
    checkOutput("tie_second_ready", FIRST_LS ? bus.if_req_ready : bus.ls_req_ready, 64'd1);
    tick();
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    checkOutput("tie_second_addr", bus.mem_addr, FIRST_LS ? 64'h8000_0000 : 64'h2008);
    serveMem(FIRST_LS ? 64'hCAFEBABE_DEADBEEF : 64'h0123456789ABCDEF);
    checkOutput("tie_second_rsp", FIRST_LS ? bus.if_rsp_valid : bus.ls_rsp_valid, 64'd1);
    checkOutput("tie_second_data", FIRST_LS ? {32'd0, bus.if_rsp_data} : bus.ls_rsp_data,
                FIRST_LS ? 64'hDEADBEEF : 64'h0123456789ABCDEF);
    tick();
    checkOutput("tie_done_idle", busy, 64'd0);

    ifFetch("if_hi", 64'h8000_0004, 64'h11112222_33334444, 32'h11112222);

    lsAccess("sb", 1'b1, LB, 64'h1005, 64'hAB, 64'h5555, 8'h20, 64'hABABABABABABABAB, 64'h0);
    lsAccess("sh", 1'b1, LH, 64'h1006, 64'h1234, 64'h5555, 8'hC0, 64'h1234123412341234, 64'h0);
    lsAccess("sw", 1'b1, LW, 64'h1000, 64'h89ABCDEF, 64'h0, 8'h0F, 64'h89ABCDEF89ABCDEF, 64'h0);
    lsAccess("sd", 1'b1, LD, 64'h1008, 64'h0011223344556677, 64'h0, 8'hFF,
             64'h0011223344556677, 64'h0);
    lsAccess("lb", 1'b0, LB, 64'h2007, 64'h0, 64'h8011223344556677, 8'h00, 64'h0,
             64'hFFFFFFFFFFFFFF80);
    lsAccess("lbu", 1'b0, LBU, 64'h2007, 64'h0, 64'h8011223344556677, 8'h00, 64'h0, 64'h80);
    lsAccess("lh", 1'b0, LH, 64'h2002, 64'h0, 64'h00000000F00D0000, 8'h00, 64'h0,
             64'hFFFFFFFFFFFFF00D);
    lsAccess("lhu", 1'b0, LHU, 64'h2002, 64'h0, 64'h00000000F00D0000, 8'h00, 64'h0, 64'hF00D);
    lsAccess("lw", 1'b0, LW, 64'h2004, 64'h0, 64'h8765432100000000, 8'h00, 64'h0,
             64'hFFFFFFFF87654321);
    lsAccess("lwu", 1'b0, LWU, 64'h2004, 64'h0, 64'h8765432100000000, 8'h00, 64'h0,
             64'h0000000087654321);
    lsAccess("lw_misalign", 1'b0, LW, 64'h2006, 64'h0, 64'h8765432100000000, 8'h00, 64'h0,
             64'hFFFFFFFF87654321);
    lsAccess("ld", 1'b0, LD, 64'h2000, 64'h0, 64'h0123456789ABCDEF, 8'h00, 64'h0,
             64'h0123456789ABCDEF);

    // Memory stalls the request for five cycles.
    applyStimulus(1'b0, LD, 64'h3010, 64'h0);
    tick();
    bus.ls_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_req_valid", bus.mem_req_valid, 64'd1);
      checkOutput("stall_addr", bus.mem_addr, 64'h3010);
      checkOutput("stall_no_rsp", bus.ls_rsp_valid, 64'd0);
      tick();
    end
    serveMem(64'hFEDCBA9876543210);
    checkOutput("stall_rsp_valid", bus.ls_rsp_valid, 64'd1);
    checkOutput("stall_rsp_data", bus.ls_rsp_data, 64'hFEDCBA9876543210);
    tick();

    // Stray memory response while idle.
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hDEADDEADDEADDEAD;
    tick();
    bus.mem_rsp_valid = 1'b0;
    checkOutput("spur_busy", busy, 64'd0);
    checkOutput("spur_ls_rsp", bus.ls_rsp_valid, 64'd0);
    checkOutput("spur_if_rsp", bus.if_rsp_valid, 64'd0);
    checkOutput("spur_ls_data", bus.ls_rsp_data, 64'hFEDCBA9876543210);
    tick();
    checkOutput("spur_still_idle", busy, 64'd0);

    // Reset while waiting for the memory, then a late response.
    applyStimulus(1'b0, LD, 64'h4000, 64'h0);
    tick();
    bus.ls_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checkOutput("abort_in_wait", busy, 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("abort_busy", busy, 64'd0);
    checkOutput("abort_req_valid", bus.mem_req_valid, 64'd0);
    checkOutput("abort_ls_rsp", bus.ls_rsp_valid, 64'd0);
    checkOutput("abort_if_rsp", bus.if_rsp_valid, 64'd0);
    rst               = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h1234567812345678;
    tick();
    bus.mem_rsp_valid = 1'b0;
    checkOutput("late_rsp_busy", busy, 64'd0);
    checkOutput("late_rsp_ls", bus.ls_rsp_valid, 64'd0);
    tick();
    checkOutput("late_rsp_ls_after", bus.ls_rsp_valid, 64'd0);
    checkOutput("late_rsp_ls_data", bus.ls_rsp_data, 64'd0);

    ifFetch("if_recover", 64'h8000_000C, 64'hAAAA5555_BBBB6666, 32'hAAAA5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_mem_arbiter.md
Name: ysyx_220066_mem_arbiter

Overview:
- Shares one 64-bit single-port memory between instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sequences each access through request / wait / response states with valid-ready handshakes.
- LSU side does byte-lane alignment: write mask and data replication, read extraction and sign/zero extension per MemOp.
- Sits between ysyx_220066_cpu and the DPI memory model in the top level, replacing the direct combinational memory path.

Parameters:
- AW, 64, address width.
- DW, 64, memory data width (fixed 64; lane logic assumes 8 byte lanes).

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  IFU fetch request
- if_req_ready  out  1  arbiter accepts IFU request
- if_addr  in  AW  fetch address (4-byte aligned)
- if_rsp_valid  out  1  one-cycle pulse, instruction ready
- if_rsp_data  out  32  instruction: mem word [63:32] if addr[2] else [31:0]
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  arbiter accepts LSU request
- ls_addr  in  AW  byte address
- ls_wen  in  1  1 = store, 0 = load
- ls_memop  in  3  size/sign, MemOp encoding
- ls_wdata  in  64  store data, right-aligned
- ls_rsp_valid  out  1  one-cycle pulse; load data or store ack
- ls_rsp_data  out  64  extended load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts
- mem_addr  out  AW  {addr[AW-1:3],3'b0}
- mem_wen  out  1  write enable
- mem_wmask  out  8  byte enables
- mem_wdata  out  64  lane-replicated store data
- mem_rsp_valid  in  1  memory response valid (reads and writes)
- mem_rsp_data  in  64  raw 64-bit read word
- busy  out  1  FSM not IDLE

Behaviour:
- Reset: clk and rst are the ports; rst is synchronous, active-high. FSM goes to IDLE. All *_rsp_valid, mem_req_valid, mem_wen and busy are 0. mem_wmask = 0; data outputs = 0. RR pointer points to LSU.
- FSM states:
  - IDLE: if_req_ready and ls_req_ready are asserted only here, and only for the granted side. On handshake, latch owner, addr, wen, memop and wdata, then go to REQ.
  - REQ: mem_req_valid = 1 with stable address and data. On mem_req_ready go to WAIT.
  - WAIT: on mem_rsp_valid, register the response and go to RSP.
  - RSP: owner's rsp_valid = 1 for exactly one cycle, then go to IDLE.
- Minimum latency: accept in cycle 0, mem_req_valid in cycle 1, mem_rsp_valid in cycle 2 gives rsp_valid in cycle 3. Back-to-back accept is possible in the cycle after RSP.
- Grant with both requesters valid in IDLE: LSU wins (fixed priority). The single-valid case is granted immediately.
- mem_rsp_valid outside WAIT is ignored and dropped. mem_req_ready outside REQ is ignored.
- Requesters must hold valid and payload until ready. The arbiter never drops an accepted request.
- Store lanes by memop[1:0]:
  - 00: mask = 1 << addr[2:0]; data = {8{wdata[7:0]}}.
  - 01: mask = 2'b11 << {addr[2:1],1'b0}; data = {4{wdata[15:0]}}.
  - 10: mask = addr[2] ? 8'hF0 : 8'h0F; data = {2{wdata[31:0]}}.
  - 11: mask = 8'hFF.
  - Reads drive mask 0.
- Load extraction:
  - Byte from lane addr[2:0]; half from addr[2:1]; word from addr[2].
  - memop[2] = 1 zero-extends; memop[2] = 0 sign-extends. 011 returns the raw word.
  - Low address bits below the access size are ignored; no misalign trap.
- Reset mid-operation: abort immediately to IDLE, no response pulse. A stale memory response arriving afterwards is ignored per the rule above.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-grant register is updated on each accepted request. On a tie the side not last granted wins.
- Undefined: fixed LSU priority; the register is not built.

Decomposition:
- Package ysyx_220066_mem_pkg:
  - MemOp localparams: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
  - FSM state enum {IDLE, REQ, WAIT, RSP}.
  - Owner enum {OWN_IF, OWN_LS}.
- Sub-module ysyx_220066_lsu_align (combinational): wmask/wdata generation and read extract/extend. Instantiated once and reused by the bench as a reference model.

Test Plan:
- IFU fetch alone, if_addr=0x80000004, mem_rsp_data=0x11112222_33334444 returned 1 cycle after acceptance -> if_rsp_data=0x11112222, pulse 3 cycles after accept.
- Simultaneous IFU and LSU requests -> fixed priority: LSU served first, IFU accepted after LSU RSP. With MEM_ARB_RR_EN and last grant LSU -> IFU served first.
- Store SB: addr=0x...1005, wdata=0xAB -> mem_addr=...1000, wmask=0x20, mem_wdata=0xABAB...AB, ls_rsp_data=0. Store SH at offset 6 -> wmask=0xC0.
- Load LB: offset 7, mem word 0x80xx..xx -> ls_rsp_data=0xFFFFFFFFFFFFFF80. Load LBU -> 0x80. Load LW at offset 4, data 0x8765432100000000 -> 0xFFFFFFFF87654321.
- mem_req_ready held low 5 cycles -> mem_req_valid and payload stable throughout, no rsp pulse. Spurious mem_rsp_valid in IDLE -> no output change.
- rst asserted in WAIT -> next cycle IDLE, all valids 0, no rsp pulse. Late mem_rsp_valid after reset is ignored.
